// File: rtl/alu_muldiv_seq.sv
// Sequential execute-stage ALU: single-cycle arithmetic/logic/shift ops plus an
// iterative shift-add multiplier and restoring divider writing HI/LO.
module alu_muldiv_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [5:0]         func,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               rType,
    input  logic [2:0]         fromContr,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               busy,
    output logic               done,
    output logic               div_zero,
    output logic               illegal
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SRL, OP_SLL, OP_SRA, OP_JR, OP_AND, OP_OR,
        OP_SLT, OP_MFHI, OP_MFLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_ILL
    } op_t;

    state_t               state_reg, state_next;
    op_t                  op;
    logic                 accept;
    logic [WIDTH-1:0]     result_reg, hi_reg, lo_reg, alu_val;
    logic                 zero_reg, done_reg, div_zero_reg, illegal_reg;
    logic [2*WIDTH-1:0]   p_reg;          // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]     opd_reg;        // multiplicand or divisor magnitude
    logic                 neg_q_reg, neg_r_reg;
    logic [SHAMT_W-1:0]   cnt_reg;
    logic                 last_iter, is_signed;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step, mul_fix, div_step;
    logic [WIDTH-1:0]     rem_shift, rem_sub, div_q, div_r;
    logic                 div_ge;

    assign result   = result_reg;
    assign zero     = zero_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;
    assign done     = done_reg;
    assign div_zero = div_zero_reg;
    assign illegal  = illegal_reg;

    // Decode func (R-type) or the control unit's aluOp into one operation code
    always_comb begin
        op = OP_ILL;
        if (rType) begin
            case (func)
                6'b100000: op = OP_ADD;
                6'b100010: op = OP_SUB;
                6'b000010: op = OP_SRL;
                6'b000000: op = OP_SLL;
                6'b000011: op = OP_SRA;
                6'b001000: op = OP_JR;
                6'b100100: op = OP_AND;
                6'b100101: op = OP_OR;
                6'b101010: op = OP_SLT;
                6'b010000: op = OP_MFHI;
                6'b010010: op = OP_MFLO;
                6'b011000: op = OP_MULT;
                6'b011001: op = OP_MULTU;
                6'b011010: op = OP_DIV;
                6'b011011: op = OP_DIVU;
                default:   op = OP_ILL;
            endcase
        end else begin
            case (fromContr)
                3'b001:         op = OP_OR;
                3'b010, 3'b011: op = OP_ADD;
                3'b100:         op = OP_SUB;
                3'b101:         op = OP_JR;
                3'b110:         op = OP_AND;
                3'b111:         op = OP_SLT;
                default:        op = OP_ILL;
            endcase
        end
    end

    // Single-cycle result for the non-iterative operations
    always_comb begin
        alu_val = '0;
        case (op)
            OP_ADD:  alu_val = a + b;
            OP_SUB:  alu_val = a - b;
            OP_SRL:  alu_val = b >> shamt;
            OP_SLL:  alu_val = b << shamt;
            OP_SRA:  alu_val = $signed(b) >>> shamt;
            OP_JR:   alu_val = a;
            OP_AND:  alu_val = a & b;
            OP_OR:   alu_val = a | b;
            OP_SLT:  alu_val = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MFHI: alu_val = hi_reg;
            OP_MFLO: alu_val = lo_reg;
            default: alu_val = '0;
        endcase
    end

    // Operand magnitudes and one iteration step of the multiplier and divider
    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
        last_iter = (cnt_reg == SHAMT_W'(WIDTH - 1));
        // Shift-add: add multiplicand into the upper half when the current multiplier bit is set
        mul_sum   = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + {1'b0, (p_reg[0] ? opd_reg : {WIDTH{1'b0}})};
        mul_step  = {mul_sum, p_reg[WIDTH-1:1]};
        mul_fix   = neg_q_reg ? -mul_step : mul_step;
        // Restoring step: the true partial remainder is {rem, next dividend bit}; when it
        // reaches the divisor the difference is below 2^WIDTH, so WIDTH-bit arithmetic suffices
        div_ge    = {p_reg[2*WIDTH-1:WIDTH], p_reg[WIDTH-1]} >= {1'b0, opd_reg};
        rem_shift = {p_reg[2*WIDTH-2:WIDTH], p_reg[WIDTH-1]};
        rem_sub   = rem_shift - opd_reg;
        div_step  = {(div_ge ? rem_sub : rem_shift), p_reg[WIDTH-2:0], div_ge};
        div_q     = neg_q_reg ? -div_step[WIDTH-1:0] : div_step[WIDTH-1:0];
        div_r     = neg_r_reg ? -div_step[2*WIDTH-1:WIDTH] : div_step[2*WIDTH-1:WIDTH];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // FSM next state: FIN behaves like IDLE so a new op can issue in the done cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_FIN: begin
                state_next = S_IDLE;
                if (start) begin
                    if (op == OP_MULT || op == OP_MULTU)
                        state_next = S_MUL;
                    else if ((op == OP_DIV || op == OP_DIVU) && b != '0)
                        state_next = S_DIV;
                end
            end
            S_MUL, S_DIV: if (last_iter) state_next = S_FIN;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs: busy while iterating, start only honoured when not busy
    always_comb begin
        busy   = (state_reg == S_MUL) || (state_reg == S_DIV);
        accept = start && !busy;
    end

    // Datapath: operand latch, iteration, and result/HI/LO writeback
    always_ff @(posedge clk) begin
        if (reset) begin
            result_reg   <= '0;
            zero_reg     <= 1'b1;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            illegal_reg  <= 1'b0;
            p_reg        <= '0;
            opd_reg      <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            done_reg    <= 1'b0;
            illegal_reg <= 1'b0;
            if (accept) begin
                div_zero_reg <= 1'b0;
                cnt_reg      <= '0;
                case (op)
                    OP_MULT, OP_MULTU: begin
                        opd_reg   <= a_mag;
                        p_reg     <= {{WIDTH{1'b0}}, b_mag};
                        neg_q_reg <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    end
                    OP_DIV, OP_DIVU: begin
                        if (b == '0) begin
                            lo_reg       <= '1;
                            hi_reg       <= a;
                            result_reg   <= '1;
                            zero_reg     <= 1'b0;
                            div_zero_reg <= 1'b1;
                            done_reg     <= 1'b1;
                        end else begin
                            opd_reg   <= b_mag;
                            p_reg     <= {{WIDTH{1'b0}}, a_mag};
                            neg_q_reg <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r_reg <= is_signed && a[WIDTH-1];
                        end
                    end
                    OP_ILL: begin
                        result_reg  <= '0;
                        zero_reg    <= 1'b1;
                        illegal_reg <= 1'b1;
                        done_reg    <= 1'b1;
                    end
                    default: begin
                        result_reg <= alu_val;
                        zero_reg   <= (alu_val == '0);
                        done_reg   <= 1'b1;
                    end
                endcase
            end else if (state_reg == S_MUL) begin
                p_reg   <= mul_step;
                cnt_reg <= cnt_reg + 1'b1;
                if (last_iter) begin
                    hi_reg     <= mul_fix[2*WIDTH-1:WIDTH];
                    lo_reg     <= mul_fix[WIDTH-1:0];
                    result_reg <= mul_fix[WIDTH-1:0];
                    zero_reg   <= (mul_fix[WIDTH-1:0] == '0);
                    done_reg   <= 1'b1;
                end
            end else if (state_reg == S_DIV) begin
                p_reg   <= div_step;
                cnt_reg <= cnt_reg + 1'b1;
                if (last_iter) begin
                    hi_reg     <= div_r;
                    lo_reg     <= div_q;
                    result_reg <= div_q;
                    zero_reg   <= (div_q == '0);
                    done_reg   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed and randomized checks of alu_muldiv_seq against an arithmetic reference model.
module tb_alu_muldiv_seq;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset, start, rType;
    logic [W-1:0]  a, b;
    logic [5:0]    func;
    logic [3:0]    shamt;
    logic [2:0]    fromContr;
    logic [W-1:0]  result, hi, lo;
    logic          zero, busy, done, div_zero, illegal;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    typedef enum int {
        ADD, SUB, SRL, SLL, SRA, JR, AND_, OR_, SLT, MFHI, MFLO, MULT, MULTU, DIV, DIVU, ILL
    } op_e;

    localparam logic [5:0] FUNCS [15] = '{6'h20, 6'h22, 6'h02, 6'h00, 6'h03, 6'h08, 6'h24,
                                          6'h25, 6'h2A, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B};

    always #5 clk = ~clk;

    alu_muldiv_seq #(.WIDTH(W), .SHAMT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .func(func), .shamt(shamt),
        .rType(rType), .fromContr(fromContr), .result(result), .zero(zero), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .div_zero(div_zero), .illegal(illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic op_e decode(input logic rt, input logic [5:0] fn, input logic [2:0] fc);
        if (rt) begin
            case (fn)
                6'h20: return ADD;   6'h22: return SUB;   6'h02: return SRL;
                6'h00: return SLL;   6'h03: return SRA;   6'h08: return JR;
                6'h24: return AND_;  6'h25: return OR_;   6'h2A: return SLT;
                6'h10: return MFHI;  6'h12: return MFLO;  6'h18: return MULT;
                6'h19: return MULTU; 6'h1A: return DIV;   6'h1B: return DIVU;
                default: return ILL;
            endcase
        end
        case (fc)
            3'd1: return OR_;
            3'd2, 3'd3: return ADD;
            3'd4: return SUB;
            3'd5: return JR;
            3'd6: return AND_;
            3'd7: return SLT;
            default: return ILL;
        endcase
    endfunction

    // Issue one op, follow it to done (bounded), compare against the model.
    task automatic run_op(input logic rt, input logic [5:0] fn, input logic [2:0] fc,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [3:0] sh, input int poke);
        op_e          op;
        int           sa, sb, q, r, lat, got;
        longint       p;
        logic [31:0]  p32;
        logic [W-1:0] er, ehi, elo;
        logic         eill, edz, busy_ok;
        op   = decode(rt, fn, fc);
        sa   = int'($signed(av));
        sb   = int'($signed(bv));
        ehi  = m_hi; elo = m_lo; er = '0; eill = 1'b0; edz = 1'b0; lat = 1;
        case (op)
            ADD:  er = av + bv;
            SUB:  er = av - bv;
            SRL:  er = bv >> sh;
            SLL:  er = bv << sh;
            SRA:  er = 16'(sb >>> sh);
            JR:   er = av;
            AND_: er = av & bv;
            OR_:  er = av | bv;
            SLT:  er = {15'b0, (sa < sb)};
            MFHI: er = m_hi;
            MFLO: er = m_lo;
            MULT, MULTU: begin
                if (op == MULT) p = longint'(sa) * longint'(sb);
                else            p = longint'(av) * longint'(bv);
                p32 = p[31:0];
                ehi = p32[31:16]; elo = p32[15:0]; er = elo; lat = 17;
            end
            DIV, DIVU: begin
                if (bv == '0) begin
                    elo = 16'hFFFF; ehi = av; edz = 1'b1;
                end else begin
                    if (op == DIV) begin q = sa / sb; r = sa % sb; end
                    else begin q = int'(av) / int'(bv); r = int'(av) % int'(bv); end
                    elo = q[15:0]; ehi = r[15:0]; lat = 17;
                end
                er = elo;
            end
            default: begin er = '0; eill = 1'b1; end
        endcase

        rType = rt; func = fn; fromContr = fc; a = av; b = bv; shamt = sh; start = 1'b1;
        got = 0; busy_ok = 1'b1;
        for (int c = 1; c <= 40 && got == 0; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (poke > 0 && c == poke) begin
                start = 1'b1; rType = 1'b1; func = 6'h20; a = 16'($urandom); b = 16'($urandom);
            end else if (poke > 0 && c == poke + 1) begin
                start = 1'b0;
            end
            if (done) got = c;
            else if (busy !== (lat > 1)) busy_ok = 1'b0;
        end
        $display("op=%s rt=%0d a=%h b=%h sh=%0d -> result=%h hi=%h lo=%h lat=%0d (model result=%h hi=%h lo=%h lat=%0d)",
                 op.name(), rt, av, bv, sh, result, hi, lo, got, er, ehi, elo, lat);
        check("latency", 32'(got), 32'(lat));
        check("busy_profile", 32'(busy_ok), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("result", 32'(result), 32'(er));
        check("zero", 32'(zero), 32'(er == '0));
        check("hi", 32'(hi), 32'(ehi));
        check("lo", 32'(lo), 32'(elo));
        check("illegal", 32'(illegal), 32'(eill));
        check("div_zero", 32'(div_zero), 32'(edz));
        m_hi = ehi; m_lo = elo;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [5:0]   rf;
        logic [2:0]   rc;
        logic         rt, saw_done;

        reset = 1'b1; start = 1'b0; rType = 1'b1; func = '0; fromContr = '0;
        a = '0; b = '0; shamt = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_result", 32'(result), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_hi", 32'(hi), 32'd0);
        check("rst_lo", 32'(lo), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_div_zero", 32'(div_zero), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);

        // Directed steps, issued back to back (zero bubble)
        run_op(1'b1, 6'h20, 3'd0, 16'h5BF3, 16'h0011, 4'd0, 0);   // ADD
        run_op(1'b1, 6'h22, 3'd0, 16'hFFFF, 16'hFFFF, 4'd0, 0);   // SUB -> zero
        run_op(1'b0, 6'h00, 3'd4, 16'hAF23, 16'h0022, 4'd0, 0);   // aluOp SUB
        run_op(1'b0, 6'h00, 3'd0, 16'h1234, 16'h5678, 4'd0, 0);   // aluOp illegal
        run_op(1'b1, 6'h3F, 3'd0, 16'h1234, 16'h5678, 4'd0, 0);   // func illegal
        run_op(1'b1, 6'h00, 3'd0, 16'h0000, 16'h0001, 4'd1, 0);   // SLL
        run_op(1'b1, 6'h02, 3'd0, 16'h0000, 16'h8000, 4'd4, 0);   // SRL
        run_op(1'b1, 6'h03, 3'd0, 16'h0000, 16'h8000, 4'd4, 0);   // SRA
        run_op(1'b1, 6'h2A, 3'd0, 16'hFFFF, 16'h0001, 4'd0, 0);   // SLT
        run_op(1'b1, 6'h18, 3'd0, 16'hFFFE, 16'h0003, 4'd0, 0);   // MULT
        run_op(1'b1, 6'h19, 3'd0, 16'hFFFE, 16'h0003, 4'd0, 0);   // MULTU
        run_op(1'b1, 6'h10, 3'd0, 16'h0000, 16'h0000, 4'd0, 0);   // MFHI
        run_op(1'b1, 6'h12, 3'd0, 16'h0000, 16'h0000, 4'd0, 0);   // MFLO
        run_op(1'b1, 6'h1A, 3'd0, 16'hFFF9, 16'h0002, 4'd0, 0);   // DIV
        run_op(1'b1, 6'h1B, 3'd0, 16'h0007, 16'h0000, 4'd0, 0);   // DIVU by zero
        run_op(1'b1, 6'h20, 3'd0, 16'h0001, 16'h0001, 4'd0, 0);   // clears div_zero
        run_op(1'b1, 6'h1A, 3'd0, 16'h8000, 16'hFFFF, 4'd0, 0);   // DIV corner
        run_op(1'b1, 6'h1A, 3'd0, 16'h0064, 16'h0007, 4'd0, 3);   // DIV with ignored start

        // Randomized ops against the model
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rt = ($urandom_range(0, 4) != 0);
            rf = FUNCS[$urandom_range(0, 14)];
            if ($urandom_range(0, 19) == 0) rf = 6'h3F;
            rc = 3'($urandom);
            if ($urandom_range(0, 7) == 0) rb = '0;
            if ($urandom_range(0, 9) == 0) rb = ra;
            if ($urandom_range(0, 9) == 0) ra = 16'h8000;
            run_op(rt, rf, rc, ra, rb, 4'($urandom), 0);
        end

        // Reset in the middle of a divide: aborted, no done
        rType = 1'b1; func = 6'h1A; a = 16'h0064; b = 16'h0007; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        m_hi = '0; m_lo = '0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", 32'(hi), 32'(m_hi));
        check("abort_lo", 32'(lo), 32'(m_lo));
        saw_done = done;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        $display("reset abort: busy=%0d hi=%h lo=%h", busy, hi, lo);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
